// File: rtl/arb_2to1_pkg.sv
// arb_2to1_pkg: shared NS channel constants and arbiter FSM state encodings
package arb_2to1_pkg;
  localparam logic NS_ON = 1'b1;
  localparam logic NS_OFF = 1'b0;
  localparam int NS_ADDRESS_SIZE = 8;
  localparam int NS_DATA_SIZE = 16;
  typedef enum logic [1:0] {
    NS_ARB_IDLE  = 2'd0,
    NS_ARB_SEND  = 2'd1,
    NS_ARB_DRAIN = 2'd2
  } arb_state_t;
endpackage

// File: rtl/arb_2to1_rr2.sv
// arb_rr2: combinational 2-way grant; ARB_2TO1_FIXED_PRIO_EN makes input 0 win every tie
module arb_rr2 (
  input  logic [1:0] pending,
  input  logic       r_last,
  output logic       valid,
  output logic       win
);
  logic tie_win;
`ifdef ARB_2TO1_FIXED_PRIO_EN
  logic unused_r_last;
  assign unused_r_last = r_last;
  assign tie_win = 1'b0;
`else
  assign tie_win = !r_last;
`endif
  assign valid = |pending;
  assign win = &pending ? tie_win : pending[1];
endmodule

// File: rtl/arb_2to1.sv
// arb_2to1: one-message-buffer 2-to-1 NS channel arbiter (round-robin, or fixed priority with ARB_2TO1_FIXED_PRIO_EN)
module arb_2to1
  import arb_2to1_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [ASZ-1:0] i0_src,
  input  logic [ASZ-1:0] i0_dst,
  input  logic [DSZ-1:0] i0_dat,
  input  logic           i0_req,
  output logic           i0_ack,
  input  logic [ASZ-1:0] i1_src,
  input  logic [ASZ-1:0] i1_dst,
  input  logic [DSZ-1:0] i1_dat,
  input  logic           i1_req,
  output logic           i1_ack,
  output logic [ASZ-1:0] o0_src,
  output logic [ASZ-1:0] o0_dst,
  output logic [DSZ-1:0] o0_dat,
  output logic           o0_req,
  input  logic           o0_ack,
  output logic           o_grant,
  output logic           o_err
);
  arb_state_t state;
  logic       r_last;
  logic [1:0] req_q;
  logic       valid;
  logic       win;
  arb_rr2 u_rr (
    .pending({i1_req & ~i1_ack, i0_req & ~i0_ack}),
    .r_last (r_last),
    .valid  (valid),
    .win    (win)
  );
  // Capture/replay FSM plus independent ack release and sticky req-drop error detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= NS_ARB_IDLE;
      r_last  <= NS_ON;
      req_q   <= '0;
      o_grant <= NS_OFF;
      o_err   <= NS_OFF;
      o0_req  <= NS_OFF;
      i0_ack  <= NS_OFF;
      i1_ack  <= NS_OFF;
      o0_src  <= '0;
      o0_dst  <= '0;
      o0_dat  <= '0;
    end else begin
      req_q <= {i1_req, i0_req};
      if ((req_q[0] && !i0_req && !i0_ack) || (req_q[1] && !i1_req && !i1_ack)) o_err <= NS_ON;
      if (!i0_req && i0_ack) i0_ack <= NS_OFF;
      if (!i1_req && i1_ack) i1_ack <= NS_OFF;
      case (state)
        NS_ARB_IDLE:
          if (valid) begin
            o0_src  <= win ? i1_src : i0_src;
            o0_dst  <= win ? i1_dst : i0_dst;
            o0_dat  <= win ? i1_dat : i0_dat;
            o_grant <= win;
            r_last  <= win;
            if (win) i1_ack <= NS_ON;
            else i0_ack <= NS_ON;
            o0_req  <= NS_ON;
            state   <= NS_ARB_SEND;
          end
        NS_ARB_SEND:
          if (o0_ack) begin
            o0_req <= NS_OFF;
            state  <= NS_ARB_DRAIN;
          end
        NS_ARB_DRAIN:
          if (!o0_ack) state <= NS_ARB_IDLE;
        default: state <= NS_ARB_IDLE;
      endcase
    end
  end
endmodule
